// File: rtl/dsp_reset_responder.sv
// Device-side responder for the DSP reset/detect handshake on the ISA I/O bus.
// Enforces the 1-hold-0 reset write sequence, then presents 0xAA after a release delay.
module dsp_reset_responder #(
   parameter logic [15:0] BASE_ADDR   = 16'h0220,
   parameter int unsigned HOLD_CYCLES = 3,
   parameter int unsigned READY_DELAY = 8
) (
   input  logic        sys_clock,
   input  logic        reset_n,
   input  logic [15:0] address,
   input  logic [7:0]  data_in,
   input  logic        iow_n,
   input  logic        ior_n,
   output logic [7:0]  data_out,
   output logic        data_oe,
   output logic        in_reset,
   output logic        ready
);

   localparam int unsigned HOLD_MAX = (HOLD_CYCLES > 2) ? HOLD_CYCLES : 2;
   localparam int unsigned DLY_MAX  = (READY_DELAY > 2) ? READY_DELAY : 2;
   localparam int unsigned HOLD_W   = $clog2(HOLD_MAX) + 1;
   localparam int unsigned DLY_W    = $clog2(DLY_MAX) + 1;

   localparam logic [15:0] RST_PORT   = BASE_ADDR + 16'h0006;
   localparam logic [15:0] DATA_PORT  = BASE_ADDR + 16'h000A;
   localparam logic [15:0] STAT_PORT  = BASE_ADDR + 16'h000C;
   localparam logic [15:0] AVAIL_PORT = BASE_ADDR + 16'h000E;

   localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_CYCLES);
   localparam logic [DLY_W-1:0]  DLY_LAST = DLY_W'(READY_DELAY - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_HOLD  = 2'd1,
      S_WAIT  = 2'd2,
      S_READY = 2'd3
   } state_t;

   state_t             state;
   logic [HOLD_W-1:0]  hold_cnt;
   logic [DLY_W-1:0]   dly_cnt;
   logic [7:0]         buffer;
   logic [15:0]        rd_addr;

   // [0],[1] synchroniser flops, [2] edge register
   logic [2:0]  iow_s;
   logic [2:0]  ior_s;
   // address/data sampled alongside the synchroniser so they line up with the detected edge
   logic [15:0] addr_d0;
   logic [15:0] addr_d1;
   logic        bit_d0;
   logic        bit_d1;

   logic iow_fall;
   logic ior_fall;
   logic ior_rise;
   logic rst_wr;
   logic rst_set;
   logic rst_clr;
   logic pop;
   logic unused_data;

   assign unused_data = ^data_in[7:1];

   assign iow_fall = iow_s[2] & ~iow_s[1];
   assign ior_fall = ior_s[2] & ~ior_s[1];
   assign ior_rise = ~ior_s[2] & ior_s[1];
   assign rst_wr   = iow_fall && (addr_d1 == RST_PORT);
   assign rst_set  = rst_wr & bit_d1;
   assign rst_clr  = rst_wr & ~bit_d1;
   assign pop      = ior_rise && (rd_addr == DATA_PORT) && ready;

   always_ff @(posedge sys_clock or negedge reset_n) begin
      if (!reset_n) begin
         iow_s   <= 3'b111;
         ior_s   <= 3'b111;
         addr_d0 <= 16'h0000;
         addr_d1 <= 16'h0000;
         bit_d0  <= 1'b0;
         bit_d1  <= 1'b0;
      end else begin
         iow_s   <= {iow_s[1:0], iow_n};
         ior_s   <= {ior_s[1:0], ior_n};
         addr_d0 <= address;
         addr_d1 <= addr_d0;
         bit_d0  <= data_in[0];
         bit_d1  <= bit_d0;
      end
   end

   // Handshake state machine; a reset write always wins over a pop
   always_ff @(posedge sys_clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         hold_cnt <= '0;
         dly_cnt  <= '0;
         buffer   <= 8'h00;
         rd_addr  <= 16'h0000;
         in_reset <= 1'b0;
         ready    <= 1'b0;
      end else begin
         if (ior_fall) begin
            rd_addr <= addr_d1;
         end
         case (state)
            S_IDLE: begin
               if (rst_set) begin
                  state    <= S_HOLD;
                  hold_cnt <= '0;
                  in_reset <= 1'b1;
               end
            end
            S_HOLD: begin
               if (rst_set) begin
                  hold_cnt <= '0;
               end else if (rst_clr) begin
                  in_reset <= 1'b0;
                  if (hold_cnt >= HOLD_LIM) begin
                     state   <= S_WAIT;
                     dly_cnt <= '0;
                  end else begin
                     state <= S_IDLE;
                  end
               end else if (hold_cnt < HOLD_LIM) begin
                  hold_cnt <= hold_cnt + HOLD_W'(1);
               end
            end
            S_WAIT: begin
               if (rst_set) begin
                  state    <= S_HOLD;
                  hold_cnt <= '0;
                  in_reset <= 1'b1;
               end else if (dly_cnt == DLY_LAST) begin
                  state  <= S_READY;
                  buffer <= 8'hAA;
                  ready  <= 1'b1;
               end else begin
                  dly_cnt <= dly_cnt + DLY_W'(1);
               end
            end
            S_READY: begin
               if (rst_set) begin
                  state    <= S_HOLD;
                  hold_cnt <= '0;
                  in_reset <= 1'b1;
                  buffer   <= 8'h00;
                  ready    <= 1'b0;
               end else if (pop) begin
                  state  <= S_IDLE;
                  buffer <= 8'h00;
                  ready  <= 1'b0;
               end
            end
            default: begin
               state    <= S_IDLE;
               in_reset <= 1'b0;
               ready    <= 1'b0;
               buffer   <= 8'h00;
            end
         endcase
      end
   end

   // Read decode straight from the bus pins; values from registered state
   always_comb begin
      data_out = 8'h00;
      data_oe  = 1'b0;
      if (reset_n) begin
         case (address)
            DATA_PORT: begin
               data_oe  = !ior_n;
               data_out = ready ? buffer : 8'hFF;
            end
            STAT_PORT: begin
               data_oe  = !ior_n;
               data_out = in_reset ? 8'hFF : 8'h7F;
            end
            AVAIL_PORT: begin
               data_oe  = !ior_n;
               data_out = {ready, 7'h7F};
            end
            default: begin
               data_oe  = 1'b0;
               data_out = 8'h00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dsp_reset_responder.sv
// Directed bench for dsp_reset_responder: reset handshake, timing, reads, pops and contention.
module tb_dsp_reset_responder;

   localparam int unsigned READY_DELAY = 8;

   logic        sys_clock = 1'b0;
   logic        reset_n   = 1'b0;
   logic [15:0] address   = 16'h0000;
   logic [7:0]  data_in   = 8'h00;
   logic        iow_n     = 1'b1;
   logic        ior_n     = 1'b1;
   logic [7:0]  data_out;
   logic        data_oe;
   logic        in_reset;
   logic        ready;

   int cyc      = 0;
   int n_checks = 0;
   int n_fail   = 0;

   dsp_reset_responder #(
      .BASE_ADDR   (16'h0220),
      .HOLD_CYCLES (3),
      .READY_DELAY (READY_DELAY)
   ) dut (
      .sys_clock (sys_clock),
      .reset_n   (reset_n),
      .address   (address),
      .data_in   (data_in),
      .iow_n     (iow_n),
      .ior_n     (ior_n),
      .data_out  (data_out),
      .data_oe   (data_oe),
      .in_reset  (in_reset),
      .ready     (ready)
   );

   always #5 sys_clock = ~sys_clock;
   always @(posedge sys_clock) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Write strobe held low two cycles; the edge is acted on at the 3rd clock edge after the fall
   task automatic do_write(input logic [15:0] a, input logic [7:0] d, output int commit);
      @(negedge sys_clock);
      address = a;
      data_in = d;
      iow_n   = 1'b0;
      commit  = cyc + 3;
      @(negedge sys_clock);
      @(negedge sys_clock);
      iow_n = 1'b1;
   endtask

   task automatic do_read(input logic [15:0] a, output logic [7:0] d, output logic oe);
      @(negedge sys_clock);
      address = a;
      ior_n   = 1'b0;
      #1;
      d  = data_out;
      oe = data_oe;
      @(negedge sys_clock);
      @(negedge sys_clock);
      ior_n = 1'b1;
   endtask

   task automatic wait_ready(output int seen);
      seen = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge sys_clock);
         if (ready === 1'b1) begin
            seen = cyc;
            break;
         end
      end
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      iow_n   = 1'b1;
      ior_n   = 1'b1;
      address = 16'h0000;
      data_in = 8'h00;
      repeat (2) @(negedge sys_clock);
      reset_n = 1'b1;
      @(negedge sys_clock);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      address = 16'h022A;
      ior_n   = 1'b0;
      repeat (2) @(negedge sys_clock);
      n_checks++;
      if ({in_reset, ready, data_oe} !== 3'b000) begin
         $display("FAIL reset_flags: got %b expected 000", {in_reset, ready, data_oe});
         n_fail++;
      end
      n_checks++;
      if (data_out !== 8'h00) begin
         $display("FAIL reset_data_out: got %h expected 00", data_out);
         n_fail++;
      end
      ior_n = 1'b1;
      apply_reset();
   endtask

   task automatic test_nominal();
      int c1, c2, seen;
      logic [7:0] d;
      logic oe;
      apply_reset();
      do_write(16'h0226, 8'h01, c1);
      repeat (10) @(negedge sys_clock);
      n_checks++;
      if (in_reset !== 1'b1) begin
         $display("FAIL nom_in_reset_hold: got %b expected 1", in_reset);
         n_fail++;
      end
      do_write(16'h0226, 8'h00, c2);
      wait_ready(seen);
      n_checks++;
      if (seen != c2 + READY_DELAY) begin
         $display("FAIL nom_ready_time: got cycle %0d expected %0d", seen, c2 + READY_DELAY);
         n_fail++;
      end
      n_checks++;
      if (in_reset !== 1'b0) begin
         $display("FAIL nom_in_reset_rel: got %b expected 0", in_reset);
         n_fail++;
      end
      do_read(16'h022E, d, oe);
      n_checks++;
      if ({oe, d} !== {1'b1, 8'hFF}) begin
         $display("FAIL nom_read_22e: got oe=%b d=%h expected oe=1 d=ff", oe, d);
         n_fail++;
      end
      do_read(16'h022A, d, oe);
      n_checks++;
      if ({oe, d} !== {1'b1, 8'hAA}) begin
         $display("FAIL nom_read_22a: got oe=%b d=%h expected oe=1 d=aa", oe, d);
         n_fail++;
      end
      repeat (6) @(negedge sys_clock);
      n_checks++;
      if (ready !== 1'b0) begin
         $display("FAIL nom_pop_ready: got %b expected 0", ready);
         n_fail++;
      end
      do_read(16'h022A, d, oe);
      n_checks++;
      if (d !== 8'hFF) begin
         $display("FAIL nom_read_after_pop: got %h expected ff", d);
         n_fail++;
      end
   endtask

   task automatic test_short_pulse();
      logic [7:0] d;
      logic oe;
      apply_reset();
      @(negedge sys_clock);
      address = 16'h0226;
      data_in = 8'h01;
      iow_n   = 1'b0;
      @(negedge sys_clock);
      iow_n = 1'b1;
      @(negedge sys_clock);
      data_in = 8'h00;
      iow_n   = 1'b0;
      @(negedge sys_clock);
      iow_n = 1'b1;
      @(negedge sys_clock);
      n_checks++;
      if (in_reset !== 1'b1) begin
         $display("FAIL short_first_write: got %b expected 1", in_reset);
         n_fail++;
      end
      @(negedge sys_clock);
      n_checks++;
      if (in_reset !== 1'b0) begin
         $display("FAIL short_release: got %b expected 0", in_reset);
         n_fail++;
      end
      repeat (15) @(negedge sys_clock);
      n_checks++;
      if (ready !== 1'b0) begin
         $display("FAIL short_no_ready: got %b expected 0", ready);
         n_fail++;
      end
      do_read(16'h022E, d, oe);
      n_checks++;
      if (d !== 8'h7F) begin
         $display("FAIL short_read_22e: got %h expected 7f", d);
         n_fail++;
      end
   endtask

   task automatic test_wrong_base();
      int c;
      logic [7:0] d;
      logic oe;
      apply_reset();
      do_write(16'h0246, 8'h01, c);
      repeat (3) @(negedge sys_clock);
      n_checks++;
      if (in_reset !== 1'b0) begin
         $display("FAIL wb_in_reset: got %b expected 0", in_reset);
         n_fail++;
      end
      repeat (7) @(negedge sys_clock);
      do_write(16'h0246, 8'h00, c);
      repeat (15) @(negedge sys_clock);
      n_checks++;
      if (ready !== 1'b0) begin
         $display("FAIL wb_ready: got %b expected 0", ready);
         n_fail++;
      end
      do_read(16'h024A, d, oe);
      n_checks++;
      if (oe !== 1'b0) begin
         $display("FAIL wb_oe_24a: got %b expected 0", oe);
         n_fail++;
      end
      do_read(16'h022A, d, oe);
      n_checks++;
      if (d !== 8'hFF) begin
         $display("FAIL wb_read_22a: got %h expected ff", d);
         n_fail++;
      end
      do_read(16'h022E, d, oe);
      n_checks++;
      if (d !== 8'h7F) begin
         $display("FAIL wb_read_22e: got %h expected 7f", d);
         n_fail++;
      end
      do_read(16'h0300, d, oe);
      n_checks++;
      if (oe !== 1'b0) begin
         $display("FAIL oe_300: got %b expected 0", oe);
         n_fail++;
      end
   endtask

   task automatic test_re_reset();
      int c, seen;
      logic [7:0] d;
      logic oe;
      apply_reset();
      do_write(16'h0226, 8'h01, c);
      repeat (5) @(negedge sys_clock);
      do_write(16'h0226, 8'h00, c);
      repeat (3) @(negedge sys_clock);
      do_write(16'h0226, 8'h01, c);
      @(negedge sys_clock);
      n_checks++;
      if ({in_reset, ready} !== 2'b10) begin
         $display("FAIL rr_wait_rewrite: got %b expected 10", {in_reset, ready});
         n_fail++;
      end
      repeat (5) @(negedge sys_clock);
      do_write(16'h0226, 8'h00, c);
      wait_ready(seen);
      n_checks++;
      if (seen != c + READY_DELAY) begin
         $display("FAIL rr_ready_time1: got cycle %0d expected %0d", seen, c + READY_DELAY);
         n_fail++;
      end
      do_write(16'h0226, 8'h01, c);
      @(negedge sys_clock);
      n_checks++;
      if ({in_reset, ready} !== 2'b10) begin
         $display("FAIL rr_ready_rewrite: got %b expected 10", {in_reset, ready});
         n_fail++;
      end
      do_read(16'h022A, d, oe);
      n_checks++;
      if (d !== 8'hFF) begin
         $display("FAIL rr_buffer_cleared: got %h expected ff", d);
         n_fail++;
      end
      repeat (5) @(negedge sys_clock);
      do_write(16'h0226, 8'h00, c);
      wait_ready(seen);
      n_checks++;
      if (seen != c + READY_DELAY) begin
         $display("FAIL rr_ready_time2: got cycle %0d expected %0d", seen, c + READY_DELAY);
         n_fail++;
      end
      do_read(16'h022A, d, oe);
      n_checks++;
      if (d !== 8'hAA) begin
         $display("FAIL rr_read_aa: got %h expected aa", d);
         n_fail++;
      end
   endtask

   task automatic test_async_reset();
      int c;
      apply_reset();
      do_write(16'h0226, 8'h01, c);
      repeat (2) @(negedge sys_clock);
      address = 16'h022C;
      ior_n   = 1'b0;
      #1;
      n_checks++;
      if ({data_oe, data_out} !== {1'b1, 8'hFF}) begin
         $display("FAIL hold_status_22c: got oe=%b d=%h expected oe=1 d=ff", data_oe, data_out);
         n_fail++;
      end
      reset_n = 1'b0;
      #1;
      n_checks++;
      if ({in_reset, ready, data_oe, data_out} !== {3'b000, 8'h00}) begin
         $display("FAIL async_outputs: got %b %b %b %h expected 0 0 0 00",
                  in_reset, ready, data_oe, data_out);
         n_fail++;
      end
      reset_n = 1'b1;
      ior_n   = 1'b1;
      repeat (3) @(negedge sys_clock);
      address = 16'h022C;
      #1;
      n_checks++;
      if ({in_reset, data_out} !== {1'b0, 8'h7F}) begin
         $display("FAIL async_idle: got in_reset=%b d=%h expected 0 7f", in_reset, data_out);
         n_fail++;
      end
      do_write(16'h0226, 8'h00, c);
      repeat (15) @(negedge sys_clock);
      n_checks++;
      if (ready !== 1'b0) begin
         $display("FAIL async_no_ready: got %b expected 0", ready);
         n_fail++;
      end
   endtask

   task automatic test_contention();
      int c, seen;
      apply_reset();
      do_write(16'h0226, 8'h01, c);
      repeat (5) @(negedge sys_clock);
      do_write(16'h0226, 8'h00, c);
      wait_ready(seen);
      // pop (ior rise) and reset write (iow fall) land on the same detection edge
      @(negedge sys_clock);
      address = 16'h022A;
      ior_n   = 1'b0;
      @(negedge sys_clock);
      @(negedge sys_clock);
      ior_n   = 1'b1;
      address = 16'h0226;
      data_in = 8'h01;
      iow_n   = 1'b0;
      @(negedge sys_clock);
      @(negedge sys_clock);
      iow_n = 1'b1;
      n_checks++;
      if (ready !== 1'b1) begin
         $display("FAIL cont_pre_ready: got %b expected 1", ready);
         n_fail++;
      end
      @(negedge sys_clock);
      n_checks++;
      if ({in_reset, ready} !== 2'b10) begin
         $display("FAIL cont_hold_wins: got %b expected 10", {in_reset, ready});
         n_fail++;
      end
      repeat (5) @(negedge sys_clock);
      do_write(16'h0226, 8'h00, c);
      wait_ready(seen);
      n_checks++;
      if (seen != c + READY_DELAY) begin
         $display("FAIL cont_release: got cycle %0d expected %0d", seen, c + READY_DELAY);
         n_fail++;
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_short_pulse();
      test_wrong_base();
      test_re_reset();
      test_async_reset();
      test_contention();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
